// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: phase encodings,
// default phase durations and a small BCD conversion helper.
package traffic_pkg;

  typedef enum logic [2:0] {
    StGreen  = 3'd0,
    StYellow = 3'd1,
    StRed    = 3'd2,
    StWalk   = 3'd3,
    StFlash  = 3'd4
  } phase_e;

  localparam int unsigned DefGreenT  = 20;
  localparam int unsigned DefYellowT = 3;
  localparam int unsigned DefRedT    = 15;
  localparam int unsigned DefWalkT   = 10;
  localparam int unsigned DefPedRem  = 3;

  // Packed two-digit BCD of a value in 0..99.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_down_cnt.sv
// Two-digit packed-BCD down-counter with synchronous load (load wins over dec).
module bcd_down_cnt #(
  parameter logic [7:0] RstVal = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] q,
  output logic       zero
);

  logic [7:0] q_q, q_d;

  // Next count: load, or BCD decrement with ones 0 -> 9 borrowing from tens.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (dec) begin
      if (q_q[3:0] == 4'd0) begin
        q_d = {q_q[7:4] - 4'd1, 4'd9};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] - 4'd1};
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RstVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == 8'h00);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic light phase controller: GREEN/YELLOW/RED/WALK cycle with pedestrian
// request shortening of green, and a flashing night mode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_T  = DefGreenT,
  parameter int unsigned YELLOW_T = DefYellowT,
  parameter int unsigned RED_T    = DefRedT,
  parameter int unsigned WALK_T   = DefWalkT,
  parameter int unsigned PED_REM  = DefPedRem
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] phase,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       R_out,
  output logic       G_out,
  output logic       B_out,
  output logic       ped_ack
);

  localparam logic [7:0] LoadGreen  = to_bcd(GREEN_T - 1);
  localparam logic [7:0] LoadYellow = to_bcd(YELLOW_T - 1);
  localparam logic [7:0] LoadRed    = to_bcd(RED_T - 1);
  localparam logic [7:0] LoadWalk   = to_bcd(WALK_T - 1);
  localparam logic [7:0] LoadPedRem = to_bcd(PED_REM);

  logic [1:0] ped_sync_q, night_sync_q;
  logic       ped_prev_q;
  logic       ped_s, night_s, ped_rise;

  phase_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic       blink_q, blink_d;
  logic       r_q, r_d, g_q, g_d, b_q, b_d;

  logic       cnt_load, cnt_dec, cnt_zero;
  logic [7:0] cnt_load_val, cnt_q;

  // Two-flop synchronizers plus the previous synchronized request for edge detect.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ped_sync_q   <= 2'b00;
      night_sync_q <= 2'b00;
      ped_prev_q   <= 1'b0;
    end else begin
      ped_sync_q   <= {ped_sync_q[0], ped_req};
      night_sync_q <= {night_sync_q[0], night_mode};
      ped_prev_q   <= ped_sync_q[1];
    end
  end

  assign ped_s    = ped_sync_q[1];
  assign night_s  = night_sync_q[1];
  assign ped_rise = ped_s & ~ped_prev_q;

  // Next phase, counter control, pending request and lamp decode.
  always_comb begin
    state_d      = state_q;
    blink_d      = blink_q;
    cnt_load     = 1'b0;
    cnt_load_val = 8'h00;
    cnt_dec      = 1'b0;

    if (tick) begin
      if (state_q == StFlash) begin
        blink_d = ~blink_q;
        if (!night_s) begin
          state_d      = StRed;
          cnt_load     = 1'b1;
          cnt_load_val = LoadRed;
        end
      end else if (cnt_zero) begin
        cnt_load = 1'b1;
        if (night_s) begin
          state_d      = StFlash;
          cnt_load_val = 8'h00;
        end else begin
          case (state_q)
            StGreen: begin
              state_d      = StYellow;
              cnt_load_val = LoadYellow;
            end
            StYellow: begin
              state_d      = StRed;
              cnt_load_val = LoadRed;
            end
            StRed: begin
              if (pend_q) begin
                state_d      = StWalk;
                cnt_load_val = LoadWalk;
              end else begin
                state_d      = StGreen;
                cnt_load_val = LoadGreen;
              end
            end
            default: begin
              state_d      = StGreen;
              cnt_load_val = LoadGreen;
            end
          endcase
        end
      end else if ((state_q == StGreen) && pend_q && (cnt_q > LoadPedRem)) begin
        // Packed BCD orders the same as binary, so a plain compare works.
        cnt_load     = 1'b1;
        cnt_load_val = LoadPedRem;
      end else begin
        cnt_dec = 1'b1;
      end
    end

    // A fresh edge beats the clear on WALK entry.
    pend_d = pend_q;
    if (ped_rise) begin
      pend_d = 1'b1;
    end else if ((state_d == StWalk) && (state_q != StWalk)) begin
      pend_d = 1'b0;
    end

    r_d = 1'b0;
    g_d = 1'b0;
    b_d = 1'b0;
    case (state_d)
      StGreen:  g_d = 1'b1;
      StYellow: begin
        r_d = 1'b1;
        g_d = 1'b1;
      end
      StRed:    r_d = 1'b1;
      StWalk: begin
        r_d = 1'b1;
        b_d = 1'b1;
      end
      StFlash: begin
        r_d = blink_d;
        g_d = blink_d;
      end
      default: ;
    endcase
  end

  // Phase state, pending flag, blink bit and registered lamp drives.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StRed;
      pend_q  <= 1'b0;
      blink_q <= 1'b0;
      r_q     <= 1'b1;
      g_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  bcd_down_cnt #(
    .RstVal (LoadRed)
  ) u_cnt (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .q        (cnt_q),
    .zero     (cnt_zero)
  );

  assign phase    = state_q;
  assign cnt_tens = cnt_q[7:4];
  assign cnt_ones = cnt_q[3:0];
  assign R_out    = r_q;
  assign G_out    = g_q;
  assign B_out    = b_q;
  assign ped_ack  = pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: behavioural model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_traffic_phase_ctrl;

  localparam int GreenT  = 6;
  localparam int YellowT = 2;
  localparam int RedT    = 4;
  localparam int WalkT   = 3;
  localparam int PedRem  = 2;

  localparam int PhGreen  = 0;
  localparam int PhYellow = 1;
  localparam int PhRed    = 2;
  localparam int PhWalk   = 3;
  localparam int PhFlash  = 4;

  logic clk;
  logic rst_n, rst2_n;
  logic tick, ped_req, night_mode;

  logic [2:0] phase, phase2;
  logic [3:0] tens, ones, tens2, ones2;
  logic       r_out, g_out, b_out, ack;
  logic       r2, g2, b2, ack2;

  int vectors;
  int miscompares;

  traffic_phase_ctrl #(
    .GREEN_T (GreenT), .YELLOW_T (YellowT), .RED_T (RedT), .WALK_T (WalkT), .PED_REM (PedRem)
  ) u_dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .tick       (tick),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .phase      (phase),
    .cnt_tens   (tens),
    .cnt_ones   (ones),
    .R_out      (r_out),
    .G_out      (g_out),
    .B_out      (b_out),
    .ped_ack    (ack)
  );

  traffic_phase_ctrl #(
    .GREEN_T (GreenT), .YELLOW_T (YellowT), .RED_T (12), .WALK_T (WalkT), .PED_REM (PedRem)
  ) u_red12 (
    .sys_clk    (clk),
    .sys_rst_n  (rst2_n),
    .tick       (tick),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .phase      (phase2),
    .cnt_tens   (tens2),
    .cnt_ones   (ones2),
    .R_out      (r2),
    .G_out      (g2),
    .B_out      (b2),
    .ped_ack    (ack2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    int phase;
    int rem;
    bit pend;
    bit blink;
    bit p1, p2, pp;
    bit n1, n2;
  } model_t;

  model_t m;

  function automatic int len_of(input int ph);
    case (ph)
      PhGreen:  return GreenT;
      PhYellow: return YellowT;
      PhRed:    return RedT;
      PhWalk:   return WalkT;
      default:  return 1;
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t s;
    s.phase = PhRed;
    s.rem   = RedT - 1;
    s.pend  = 0;
    s.blink = 0;
    s.p1 = 0; s.p2 = 0; s.pp = 0;
    s.n1 = 0; s.n2 = 0;
    return s;
  endfunction

  function automatic model_t model_next(input model_t s, input bit tk, input bit pr,
                                        input bit nm);
    model_t n;
    bit     press;
    int     nxt;
    n     = s;
    press = s.p2 && !s.pp;
    if (tk) begin
      if (s.phase == PhFlash) begin
        n.blink = !s.blink;
        if (!s.n2) begin
          n.phase = PhRed;
          n.rem   = RedT - 1;
        end
      end else if (s.rem == 0) begin
        if (s.n2) begin
          n.phase = PhFlash;
          n.rem   = 0;
        end else begin
          case (s.phase)
            PhGreen:  nxt = PhYellow;
            PhYellow: nxt = PhRed;
            PhRed:    nxt = s.pend ? PhWalk : PhGreen;
            default:  nxt = PhGreen;
          endcase
          n.phase = nxt;
          n.rem   = len_of(nxt) - 1;
        end
      end else if (s.phase == PhGreen && s.pend && s.rem > PedRem) begin
        n.rem = PedRem;
      end else begin
        n.rem = s.rem - 1;
      end
    end
    if (press) n.pend = 1;
    else if (n.phase == PhWalk && s.phase != PhWalk) n.pend = 0;
    n.pp = s.p2; n.p2 = s.p1; n.p1 = pr;
    n.n2 = s.n1; n.n1 = nm;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, tick, ped_req, night_mode);
  end

  // Every-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    logic [2:0] e_ph;
    logic [3:0] e_t, e_o;
    logic       e_r, e_g, e_b;
    e_ph = 3'(m.phase);
    e_t  = 4'(m.rem / 10);
    e_o  = 4'(m.rem % 10);
    e_r  = (m.phase == PhYellow) || (m.phase == PhRed) || (m.phase == PhWalk) ||
           (m.phase == PhFlash && m.blink);
    e_g  = (m.phase == PhGreen) || (m.phase == PhYellow) || (m.phase == PhFlash && m.blink);
    e_b  = (m.phase == PhWalk);
    vectors++;
    if ({phase, tens, ones, r_out, g_out, b_out, ack} !==
        {e_ph, e_t, e_o, e_r, e_g, e_b, m.pend}) begin
      miscompares++;
      $display("FAIL model t=%0t: got ph=%0d cnt=%0h%0h rgb=%b%b%b ack=%b, expected ph=%0d cnt=%0h%0h rgb=%b%b%b ack=%b",
               $time, phase, tens, ones, r_out, g_out, b_out, ack,
               e_ph, e_t, e_o, e_r, e_g, e_b, m.pend);
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_pc(input string name, input int ph, input logic [7:0] cnt);
    chk({name, ".phase"}, 32'(phase), 32'(ph));
    chk({name, ".cnt"}, 32'({tens, ones}), 32'(cnt));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] r12_exp [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; rst2_n = 1'b0;
    tick = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
    step(3);
    chk_pc("reset", PhRed, 8'h03);
    chk("reset.R", 32'(r_out), 1);
    chk("reset.G", 32'(g_out), 0);
    chk("reset.B", 32'(b_out), 0);
    chk("reset.ack", 32'(ack), 0);
    rst_n = 1'b1;

    // Free run: RED 4, GREEN 6, YELLOW 2, RED 4 ticks.
    step(1); chk_pc("run.first", PhRed, 8'h02);
    step(3); chk_pc("run.green", PhGreen, 8'h05);
    step(6); chk_pc("run.yellow", PhYellow, 8'h01);
    step(2); chk_pc("run.red", PhRed, 8'h03);
    step(4); chk_pc("run.green2", PhGreen, 8'h05);

    // Pedestrian press at GREEN 05 with ticks paused: count holds, then jumps.
    tick = 1'b0; ped_req = 1'b1;
    step(1); ped_req = 1'b0;
    step(3);
    chk_pc("hold", PhGreen, 8'h05);
    chk("ped.ack", 32'(ack), 1);
    tick = 1'b1;
    step(1); chk_pc("ped.jump", PhGreen, 8'h02);
    step(2); chk_pc("ped.g00", PhGreen, 8'h00);
    step(1); chk_pc("ped.yellow", PhYellow, 8'h01);
    step(2); chk_pc("ped.red", PhRed, 8'h03);
    step(4); chk_pc("ped.walk", PhWalk, 8'h02);
    chk("ped.walk.B", 32'(b_out), 1);
    chk("ped.walk.ack", 32'(ack), 0);
    step(3); chk_pc("ped.green", PhGreen, 8'h05);

    // Press during RED 01, then again during WALK.
    step(10); chk_pc("red01", PhRed, 8'h01);
    tick = 1'b0; ped_req = 1'b1;
    step(1); ped_req = 1'b0;
    step(3); chk("red01.ack", 32'(ack), 1);
    tick = 1'b1;
    step(2); chk_pc("walk2", PhWalk, 8'h02);
    ped_req = 1'b1;
    step(1); ped_req = 1'b0;
    step(2); chk_pc("walk2.green", PhGreen, 8'h05);
    chk("walk2.ack", 32'(ack), 1);
    step(1); chk_pc("walk2.jump", PhGreen, 8'h02);
    step(9); chk_pc("walk3", PhWalk, 8'h02);
    chk("walk3.ack", 32'(ack), 0);

    // Night mode raised mid-GREEN.
    step(3); chk_pc("night.green", PhGreen, 8'h05);
    night_mode = 1'b1;
    step(6); chk_pc("night.flash", PhFlash, 8'h00);
    chk("flash0.RG", 32'({r_out, g_out}), 0);
    step(1); chk("flash1.RG", 32'({r_out, g_out}), 3);
    step(1); chk("flash2.RG", 32'({r_out, g_out}), 0);
    night_mode = 1'b0;
    step(3); chk_pc("night.exit", PhRed, 8'h03);

    // Asynchronous reset mid-YELLOW.
    step(4); chk_pc("ar.green", PhGreen, 8'h05);
    step(6); chk_pc("ar.yellow", PhYellow, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk_pc("ar.async", PhRed, 8'h03);
    chk("ar.R", 32'(r_out), 1);
    chk("ar.G", 32'(g_out), 0);
    step(1); rst_n = 1'b1;
    step(1); chk_pc("ar.first", PhRed, 8'h02);

    // Short pause mid-phase, then free run under the model.
    tick = 1'b0;
    step(3); chk_pc("pause", PhRed, 8'h02);
    tick = 1'b1;
    step(20);

    // RED_T=12 instance: BCD wrap through 11..00.
    rst2_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step(1);
      chk($sformatf("red12[%0d]", i), 32'({tens2, ones2}), 32'(r12_exp[i]));
    end
    chk("red12.phase", 32'(phase2), PhRed);
    step(1);
    chk("red12.green", 32'({phase2, tens2, ones2}), 32'({3'd0, 8'h05}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
